// File: rtl/fpga_io_ctrl.sv
// ---------------------------------------------------------------------------
// fpga_io_ctrl
//   APB3 FPGA I/O and benchmark-timer block for the MPS2 SMM peripheral bus.
//   - LED register driving the leds outputs.
//   - Push-button inputs: 2-flop synchroniser, per-bit debounce, and sticky
//     edge flags (INTSTAT) that are OR-ed onto irq.
//   - Cycle counter advanced once per PRESCALE+1 clocks by a down-counter.
//
// Ports
//   PCLK     in   1         sole clock, rising edge
//   PRESETn  in   1         synchronous active-low reset
//   PSEL     in   1         APB select
//   PADDR    in   [11:2]    APB word address
//   PENABLE  in   1         APB access phase
//   PWRITE   in   1         APB write
//   PWDATA   in   32        APB write data
//   PRDATA   out  32        read data, 0 unless PSEL & ~PWRITE
//   PREADY   out  1         always 1 (zero wait states)
//   PSLVERR  out  1         error response in the access phase
//   buttons  in   NUM_BTNS  raw asynchronous button levels
//   leds     out  NUM_LEDS  LED drive
//   irq      out  1         level interrupt, OR of INTSTAT
//
// Register map (byte offset)
//   0x000 LED  RW | 0x008 BUTTON RO | 0x00C INTSTAT W1C | 0x010 RISE_EN RW
//   0x014 FALL_EN RW | 0x018 CYCLE RW | 0x01C PRESCALE RW | 0x020 PSCNTR RW
// ---------------------------------------------------------------------------
module fpga_io_ctrl #(
  parameter int NUM_LEDS  = 2,
  parameter int NUM_BTNS  = 2,
  parameter int DB_CYCLES = 1000,
  parameter int DB_W      = 16,
  parameter int CNT_W     = 32
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic [11:2]         PADDR,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [NUM_BTNS-1:0] buttons,
  output logic [NUM_LEDS-1:0] leds,
  output logic                irq
);

  // Word addresses (byte offset >> 2).
  localparam logic [9:0] A_LED      = 10'h000;
  localparam logic [9:0] A_BUTTON   = 10'h002;
  localparam logic [9:0] A_INTSTAT  = 10'h003;
  localparam logic [9:0] A_RISE_EN  = 10'h004;
  localparam logic [9:0] A_FALL_EN  = 10'h005;
  localparam logic [9:0] A_CYCLE    = 10'h006;
  localparam logic [9:0] A_PRESCALE = 10'h007;
  localparam logic [9:0] A_PSCNTR   = 10'h008;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // APB handshake: a transfer is the setup phase (PSEL & ~PENABLE) followed
  // by one access phase (PSEL & PENABLE). PREADY is constant 1, so every
  // access phase completes at the next PCLK edge; writes commit on that edge
  // and PSLVERR is only meaningful while PSEL & PENABLE.

  // Architectural state
  logic [NUM_LEDS-1:0] led_q,      led_d;
  logic [NUM_BTNS-1:0] rise_en_q,  rise_en_d;
  logic [NUM_BTNS-1:0] fall_en_q,  fall_en_d;
  logic [NUM_BTNS-1:0] intstat_q,  intstat_d;
  logic [CNT_W-1:0]    cycle_q,    cycle_d;
  logic [CNT_W-1:0]    prescale_q, prescale_d;
  logic [CNT_W-1:0]    pscntr_q,   pscntr_d;

  // Button path
  logic [NUM_BTNS-1:0] sync1_q;
  logic [NUM_BTNS-1:0] sync2_q;
  logic [NUM_BTNS-1:0] state_q,    state_d;
  logic [DB_W-1:0]     db_cnt_q [NUM_BTNS];
  logic [DB_W-1:0]     db_cnt_d [NUM_BTNS];

  // Decode
  logic sel_led, sel_button, sel_intstat, sel_rise_en, sel_fall_en;
  logic sel_cycle, sel_prescale, sel_pscntr, mapped;
  logic access, wr_en;
  logic [NUM_BTNS-1:0] w1c_mask;
  logic [NUM_BTNS-1:0] rise_evt, fall_evt;
  logic [31:0] rdata;

  always_comb begin
    sel_led      = (PADDR == A_LED);
    sel_button   = (PADDR == A_BUTTON);
    sel_intstat  = (PADDR == A_INTSTAT);
    sel_rise_en  = (PADDR == A_RISE_EN);
    sel_fall_en  = (PADDR == A_FALL_EN);
    sel_cycle    = (PADDR == A_CYCLE);
    sel_prescale = (PADDR == A_PRESCALE);
    sel_pscntr   = (PADDR == A_PSCNTR);
    mapped       = sel_led | sel_button | sel_intstat | sel_rise_en |
                   sel_fall_en | sel_cycle | sel_prescale | sel_pscntr;
    access       = PSEL & PENABLE;
    // Unmapped offsets match no select, so they never change state.
    wr_en        = access & PWRITE;
  end

  // Debounce: a bit is accepted only after sync2 has disagreed with the
  // accepted state for DB_CYCLES consecutive edges; any agreement restarts.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_BTNS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != state_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          state_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Register next-state
  always_comb begin
    led_d      = led_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    prescale_d = prescale_q;
    if (wr_en && sel_led)      led_d      = PWDATA[NUM_LEDS-1:0];
    if (wr_en && sel_rise_en)  rise_en_d  = PWDATA[NUM_BTNS-1:0];
    if (wr_en && sel_fall_en)  fall_en_d  = PWDATA[NUM_BTNS-1:0];
    if (wr_en && sel_prescale) prescale_d = PWDATA[CNT_W-1:0];

    // Edge flags: a new set wins over a W1C of the same bit in that cycle.
    rise_evt  = state_d & ~state_q;
    fall_evt  = ~state_d & state_q;
    w1c_mask  = (wr_en && sel_intstat) ? PWDATA[NUM_BTNS-1:0] : '0;
    intstat_d = (intstat_q & ~w1c_mask) |
                (rise_evt & rise_en_q) | (fall_evt & fall_en_q);

    // Prescaler reloads from PRESCALE on reaching zero, so the cycle counter
    // ticks once every PRESCALE+1 clocks.
    if (wr_en && (sel_pscntr || sel_prescale)) begin
      pscntr_d = PWDATA[CNT_W-1:0];
    end else if (pscntr_q == '0) begin
      pscntr_d = prescale_q;
    end else begin
      pscntr_d = pscntr_q - CNT_W'(1);
    end

    if (wr_en && sel_cycle) begin
      cycle_d = PWDATA[CNT_W-1:0];
    end else if (pscntr_q == '0) begin
      cycle_d = cycle_q + CNT_W'(1);
    end else begin
      cycle_d = cycle_q;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      led_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      intstat_q  <= '0;
      cycle_q    <= '0;
      prescale_q <= '0;
      pscntr_q   <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= '0;
      for (int i = 0; i < NUM_BTNS; i++) db_cnt_q[i] <= '0;
    end else begin
      led_q      <= led_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      intstat_q  <= intstat_d;
      cycle_q    <= cycle_d;
      prescale_q <= prescale_d;
      pscntr_q   <= pscntr_d;
      sync1_q    <= buttons;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      for (int i = 0; i < NUM_BTNS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Read mux; high bits beyond each register's width read as zero.
  always_comb begin
    rdata = '0;
    case (PADDR)
      A_LED:      rdata = 32'(led_q);
      A_BUTTON:   rdata = 32'(state_q);
      A_INTSTAT:  rdata = 32'(intstat_q);
      A_RISE_EN:  rdata = 32'(rise_en_q);
      A_FALL_EN:  rdata = 32'(fall_en_q);
      A_CYCLE:    rdata = 32'(cycle_q);
      A_PRESCALE: rdata = 32'(prescale_q);
      A_PSCNTR:   rdata = 32'(pscntr_q);
      default:    rdata = '0;
    endcase
  end

  assign PRDATA  = (PSEL && !PWRITE) ? rdata : 32'h0;
  assign PREADY  = 1'b1;
  assign PSLVERR = access & (~mapped | (PWRITE & sel_button));
  assign leds    = led_q;
  assign irq     = |intstat_q;

endmodule

// File: tb/tb_fpga_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fpga_io_ctrl
//   Directed bench for fpga_io_ctrl with NUM_LEDS=4, NUM_BTNS=2,
//   DB_CYCLES=4. Expected values are hand-derived from the register
//   behaviour; timing-sensitive checks observe PRDATA in an APB setup phase
//   (PSEL=1, PENABLE=0, PWRITE=0), which reads without side effects.
// ---------------------------------------------------------------------------
module tb_fpga_io_ctrl;
  localparam int NUM_LEDS  = 4;
  localparam int NUM_BTNS  = 2;
  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 16;
  localparam int CNT_W     = 32;

  localparam logic [11:0] R_LED      = 12'h000;
  localparam logic [11:0] R_UNMAP4   = 12'h004;
  localparam logic [11:0] R_BUTTON   = 12'h008;
  localparam logic [11:0] R_INTSTAT  = 12'h00C;
  localparam logic [11:0] R_RISE_EN  = 12'h010;
  localparam logic [11:0] R_FALL_EN  = 12'h014;
  localparam logic [11:0] R_CYCLE    = 12'h018;
  localparam logic [11:0] R_PRESCALE = 12'h01C;
  localparam logic [11:0] R_PSCNTR   = 12'h020;
  localparam logic [11:0] R_UNMAP100 = 12'h100;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                psel = 1'b0;
  logic                penable = 1'b0;
  logic                pwrite = 1'b0;
  logic [11:2]         paddr = '0;
  logic [31:0]         pwdata = '0;
  logic [31:0]         prdata;
  logic                pready;
  logic                pslverr;
  logic [NUM_BTNS-1:0] buttons = '0;
  logic [NUM_LEDS-1:0] leds;
  logic                irq;

  int tests_run    = 0;
  int tests_failed = 0;

  fpga_io_ctrl #(
    .NUM_LEDS (NUM_LEDS),
    .NUM_BTNS (NUM_BTNS),
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (DB_W),
    .CNT_W    (CNT_W)
  ) dut (
    .PCLK   (clk),
    .PRESETn(rst_n),
    .PSEL   (psel),
    .PADDR  (paddr),
    .PENABLE(penable),
    .PWRITE (pwrite),
    .PWDATA (pwdata),
    .PRDATA (prdata),
    .PREADY (pready),
    .PSLVERR(pslverr),
    .buttons(buttons),
    .leds   (leds),
    .irq    (irq)
  );

  // Driver tasks -----------------------------------------------------------
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data,
                           output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr[11:2]; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data,
                          output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr[11:2];
    @(posedge clk); #1;
    penable = 1'b1;
    #1 data = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic peek_setup(input logic [11:0] addr);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr[11:2];
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Scenarios --------------------------------------------------------------
  task automatic test_reset();
    logic        err;
    logic [31:0] d;
    logic [11:0] zero_regs [6];
    zero_regs = '{R_LED, R_RISE_EN, R_FALL_EN, R_PRESCALE, R_PSCNTR, R_INTSTAT};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    tests_run++;
    if (leds !== 4'h0 || irq !== 1'b0 || prdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: leds=%h irq=%b prdata=%h want 0/0/0", leds, irq, prdata);
    end

    // Traffic before the mid-run reset.
    apb_write(R_LED, 32'h5, err);
    apb_write(R_RISE_EN, 32'h3, err);
    apb_write(R_FALL_EN, 32'h3, err);
    apb_write(R_PRESCALE, 32'h7, err);
    apb_write(R_CYCLE, 32'd100, err);
    tests_run++;
    if (leds !== 4'h5) begin
      tests_failed++;
      $display("FAIL reset_pre_led: leds=%h want 5", leds);
    end

    // Partial debounce progress, then a single-edge reset.
    @(posedge clk); #1;
    buttons = 2'b11;
    peek_setup(R_BUTTON);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    peek_setup(R_CYCLE);
    #1;
    tests_run++;
    if (prdata !== 32'h0 || leds !== 4'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: cycle=%h leds=%h irq=%b want 0/0/0", prdata, leds, irq);
    end

    // Debounce restarts from scratch: acceptance 6 edges after the reset edge.
    peek_setup(R_BUTTON);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (prdata !== ((k == 6) ? 32'h3 : 32'h0)) begin
        tests_failed++;
        $display("FAIL reset_db_restart k=%0d: got %h want %h", k, prdata,
                 (k == 6) ? 32'h3 : 32'h0);
      end
    end
    bus_idle();

    for (int i = 0; i < 6; i++) begin
      apb_read(zero_regs[i], d, err);
      tests_run++;
      if (d !== 32'h0 || err !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_reg addr=%h: got %h err=%b want 0 err=0", zero_regs[i], d, err);
      end
    end

    buttons = 2'b00;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_debounce();
    @(posedge clk); #1;
    peek_setup(R_BUTTON);
    buttons = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (prdata !== ((k == 6) ? 32'h1 : 32'h0)) begin
        tests_failed++;
        $display("FAIL debounce_latency k=%0d: got %h want %h", k, prdata,
                 (k == 6) ? 32'h1 : 32'h0);
      end
    end

    buttons = 2'b00;
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (prdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL debounce_release: got %h want 0", prdata);
    end

    // 3-cycle glitch must never be accepted.
    buttons = 2'b01;
    repeat (3) @(posedge clk);
    #1 buttons = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (prdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL debounce_glitch k=%0d: got %h want 0", k, prdata);
      end
    end
    bus_idle();
  endtask

  task automatic test_irq();
    logic        err;
    logic [31:0] d;

    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_idle: got %b want 0", irq);
    end

    apb_write(R_RISE_EN, 32'h1, err);
    buttons = 2'b01;
    repeat (8) @(posedge clk);
    apb_read(R_INTSTAT, d, err);
    tests_run++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_rise: intstat=%h irq=%b want 1/1", d, irq);
    end

    buttons = 2'b00;
    repeat (8) @(posedge clk);
    apb_read(R_INTSTAT, d, err);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL irq_release_nochange: intstat=%h want 1", d);
    end

    apb_write(R_INTSTAT, 32'h1, err);
    apb_read(R_INTSTAT, d, err);
    tests_run++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_w1c: intstat=%h irq=%b want 0/0", d, irq);
    end

    // W1C access edge coincides with the edge that accepts the press.
    @(posedge clk); #1;
    buttons = 2'b01;
    repeat (4) @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = R_INTSTAT[11:2]; pwdata = 32'h1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    bus_idle();
    pwdata = '0;
    apb_read(R_INTSTAT, d, err);
    tests_run++;
    if (d !== 32'h1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_set_beats_w1c: intstat=%h irq=%b want 1/1", d, irq);
    end

    apb_write(R_RISE_EN, 32'h0, err);
    apb_read(R_INTSTAT, d, err);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL irq_enable_clear_keeps_flag: intstat=%h want 1", d);
    end
    apb_write(R_INTSTAT, 32'h1, err);

    // Falling-edge enable on button 1 only.
    apb_write(R_FALL_EN, 32'h2, err);
    buttons = 2'b11;
    repeat (8) @(posedge clk);
    apb_read(R_INTSTAT, d, err);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL irq_fall_on_press: intstat=%h want 0", d);
    end
    buttons = 2'b00;
    repeat (8) @(posedge clk);
    apb_read(R_INTSTAT, d, err);
    tests_run++;
    if (d !== 32'h2 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_fall: intstat=%h irq=%b want 2/1", d, irq);
    end
    apb_write(R_INTSTAT, 32'h3, err);
    apb_write(R_FALL_EN, 32'h0, err);
  endtask

  task automatic test_counters();
    logic        err;
    logic [31:0] d;
    logic [31:0] exp;

    // PRESCALE=3: CYCLE advances once every 4 clocks.
    apb_write(R_PRESCALE, 32'h3, err);
    apb_write(R_CYCLE, 32'h0, err);
    peek_setup(R_CYCLE);
    #1;
    tests_run++;
    if (prdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL cycle_ps3 k=0: got %h want 0", prdata);
    end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp = 32'((k + 3) / 4);
      tests_run++;
      if (prdata !== exp) begin
        tests_failed++;
        $display("FAIL cycle_ps3 k=%0d: got %h want %h", k, prdata, exp);
      end
    end
    bus_idle();

    // PRESCALE write reloads PSCNTR, which then counts down.
    apb_write(R_PRESCALE, 32'd10, err);
    apb_read(R_PSCNTR, d, err);
    tests_run++;
    if (d !== 32'd8) begin
      tests_failed++;
      $display("FAIL pscntr_load: got %0d want 8", d);
    end

    // PRESCALE=0: +1 per clock, wrap from all-ones.
    apb_write(R_PRESCALE, 32'h0, err);
    apb_write(R_CYCLE, 32'hFFFF_FFFF, err);
    peek_setup(R_CYCLE);
    #1;
    tests_run++;
    if (prdata !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL cycle_write: got %h want ffffffff", prdata);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      exp = 32'(k - 1);
      tests_run++;
      if (prdata !== exp) begin
        tests_failed++;
        $display("FAIL cycle_wrap k=%0d: got %h want %h", k, prdata, exp);
      end
    end
    bus_idle();
  endtask

  task automatic test_apb_errors();
    logic        err;
    logic [31:0] d;

    apb_write(R_BUTTON, 32'h3, err);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_button_write: pslverr=%b want 1", err);
    end
    apb_read(R_BUTTON, d, err);
    tests_run++;
    if (d !== 32'h0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_button_unchanged: got %h err=%b want 0 err=0", d, err);
    end

    apb_read(R_UNMAP100, d, err);
    tests_run++;
    if (d !== 32'h0 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_unmapped_read: got %h err=%b want 0 err=1", d, err);
    end

    apb_write(R_LED, 32'hFFFF_FFFF, err);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_led_write: pslverr=%b want 0", err);
    end
    apb_read(R_LED, d, err);
    tests_run++;
    if (d !== 32'hF || leds !== 4'hF) begin
      tests_failed++;
      $display("FAIL led_width: read=%h leds=%h want f/f", d, leds);
    end

    apb_write(R_UNMAP100, 32'h0, err);
    tests_run++;
    if (err !== 1'b1 || leds !== 4'hF) begin
      tests_failed++;
      $display("FAIL err_unmapped_write100: err=%b leds=%h want 1/f", err, leds);
    end
    apb_write(R_UNMAP4, 32'h0, err);
    tests_run++;
    if (err !== 1'b1 || leds !== 4'hF) begin
      tests_failed++;
      $display("FAIL err_unmapped_write4: err=%b leds=%h want 1/f", err, leds);
    end

    #1;
    tests_run++;
    if (prdata !== 32'h0 || pslverr !== 1'b0 || pready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bus_idle_outputs: prdata=%h pslverr=%b pready=%b want 0/0/1",
               prdata, pslverr, pready);
    end
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Sequence and report
  initial begin
    test_reset();
    test_debounce();
    test_irq();
    test_counters();
    test_apb_errors();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
